lcd_bus_reader: RTL and testbench
=================================

// Module: lcd_bus_reader
// PURPOSE
//  Read-side engine for the HD44780-compatible 8-bit character LCD bus used by the
//  operand/result display. Performs timed read cycles (RW=1): busy-flag/address reads
//  (RS=0) and DDRAM data reads (RS=1), with an optional busy-poll mode.
//  Sits beside the LCD write engine; owns the bus only when granted.
// PARAMETERS
//  T_AS      3     clk cycles RS/RW stable before E rises (60 ns at 50 MHz)
//  T_EH      25    clk cycles E held high; data sampled on last cycle (>=450 ns)
//  T_EL      25    clk cycles E low after fall before next cycle or release (>=500 ns)
//  POLL_MAX  1023  max busy-flag reads in poll mode before timeout
// PORTS
//  clk          in   1  50 MHz system clock
//  lcd_reset    in   1  synchronous reset, active low
//  req_valid    in   1  read request present
//  req_ready    out  1  high in IDLE only; request accepted when valid&&ready
//  req_rs       in   1  0 = busy flag/address read, 1 = DDRAM data read
//  req_poll     in   1  with req_rs=0: repeat reads until BF=0 or timeout
//  bus_req      out  1  request LCD bus from the write engine
//  bus_gnt      in   1  bus granted; writer has released lcd_data
//  lcd_data_in  in   8  LCD data bus input (from inout pad)
//  lcd_data_oe  out  1  data pad output enable; always 0 from this block
//  lcd_rs       out  1  LCD register select
//  lcd_rw       out  1  LCD read/write select (1 = read while bus owned)
//  lcd_e        out  1  LCD enable strobe
//  rsp_valid    out  1  one-cycle pulse: response fields valid
//  rsp_data     out  8  sampled byte (DDRAM char, or {BF,AC[6:0]})
//  rsp_busy     out  1  BF (bit 7) of last sample when req_rs=0, else 0
//  rsp_timeout  out  1  poll mode ended on POLL_MAX with BF still 1
// BEHAVIOUR
//  Reset (lcd_reset=0 at clk edge): state=IDLE; bus_req=0, lcd_rs=0, lcd_rw=0,
//   lcd_e=0, lcd_data_oe=0, rsp_valid=0, rsp_data=0, rsp_busy=0, rsp_timeout=0,
//   req_ready=1 from first cycle after reset release. Reset mid-cycle aborts at once:
//   E drops, bus released same edge, no rsp_valid.
//  FSM: IDLE -> ARB -> SETUP -> EHIGH -> ELOW -> (SETUP | DONE) -> IDLE.
//   IDLE: req_ready=1; on accept latch rs/poll, clear poll count, go ARB.
//   ARB: bus_req=1; wait for bus_gnt (unbounded). On gnt -> SETUP.
//   SETUP: lcd_rw=1, lcd_rs=latched rs, lcd_e=0, T_AS cycles.
//   EHIGH: lcd_e=1 for T_EH cycles; lcd_data_in captured on final EHIGH cycle.
//   ELOW: lcd_e=0 for T_EL cycles, RS/RW held. Then: if poll && BF=1 && count<POLL_MAX
//    -> count++, SETUP (bus kept); else DONE.
//   DONE: rsp_valid=1 for one cycle; lcd_rw=0, bus_req=0 same cycle; -> IDLE.
//  Latency single read: accept->rsp_valid = 1 + arb_wait + T_AS+T_EH+T_EL + 1 cycles
//   (= 55 + arb_wait at defaults). Poll: N reads -> N*(T_AS+T_EH+T_EL) + 2 + arb_wait.
//  bus_gnt deasserted while owned is a protocol error: ignored, cycle completes.
//  lcd_rw stays 1 continuously from SETUP through last ELOW of a poll sequence.
//  Poll count counts reads performed; POLL_MAX reads all BF=1 -> rsp_timeout=1,
//   rsp_busy=1, rsp_data = last sample. req_poll ignored when req_rs=1.
//  req_valid during non-IDLE not accepted (req_ready=0); no queuing.
//  Response regs hold until next rsp_valid.
// TESTING
//  1 reset: hold lcd_reset=0 5 cycles mid-EHIGH -> lcd_e=0, bus_req=0, no rsp_valid.
//  2 rs=0 read, gnt immediate, data_in=8'h4A -> rsp_valid at cycle 55, data 4A, busy 0.
//  3 rs=1 read, data_in=8'h33 ('3') -> lcd_rs=1 through EHIGH, rsp_data=33, busy 0.
//  4 poll, data_in=8'hC5 for 3 reads then 8'h45 -> 4 E pulses, rsp_data=45, timeout 0.
//  5 poll, POLL_MAX=4, data_in stuck 8'h80 -> exactly 4 E pulses, timeout=1, busy=1.
//  6 bus_gnt held 0 for 100 cycles -> lcd_rw=0, lcd_e=0 throughout; then normal read.

Source files
------------

// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780-style 8-bit LCD bus: arbitrates for the bus, runs
// timed RW=1 cycles (busy-flag/address or DDRAM data), and optionally polls until BF clears.
module lcd_bus_reader #(
    parameter int unsigned T_AS     = 3,
    parameter int unsigned T_EH     = 25,
    parameter int unsigned T_EL     = 25,
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic       clk,
    input  logic       lcd_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       bus_req,
    input  logic       bus_gnt,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_data_oe,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_busy,
    output logic       rsp_timeout
);

    localparam int unsigned T_MAX   = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                                    : ((T_EH > T_EL) ? T_EH : T_EL);
    localparam int unsigned TIMER_W = $clog2(T_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(POLL_MAX + 1);

    localparam logic [TIMER_W-1:0] AS_LOAD  = TIMER_W'(T_AS - 1);
    localparam logic [TIMER_W-1:0] EH_LOAD  = TIMER_W'(T_EH - 1);
    localparam logic [TIMER_W-1:0] EL_LOAD  = TIMER_W'(T_EL - 1);
    localparam logic [CNT_W-1:0]   POLL_LIM = CNT_W'(POLL_MAX);

    typedef enum logic [2:0] {IDLE, ARB, SETUP, EHIGH, ELOW, DONE} state_t;

    state_t               state, state_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic [CNT_W-1:0]     poll_cnt;
    logic [7:0]           sample_q;
    logic                 rs_q;
    logic                 poll_q;
    logic                 accept;
    logic                 capture;
    logic                 owned_next;
    logic                 again;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign capture     = (state == EHIGH) && (timer == '0);
    assign lcd_data_oe = 1'b0;
    // poll_cnt already includes the read that just finished, so POLL_MAX reads is the cap.
    assign again       = poll_q && sample_q[7] && (poll_cnt < POLL_LIM);
    assign owned_next  = (state_next == SETUP) || (state_next == EHIGH) || (state_next == ELOW);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE:  if (accept) state_next = ARB;
            ARB:   if (bus_gnt) begin
                       state_next = SETUP;
                       timer_next = AS_LOAD;
                   end
            SETUP: if (timer == '0) begin
                       state_next = EHIGH;
                       timer_next = EH_LOAD;
                   end else begin
                       timer_next = timer - 1'b1;
                   end
            EHIGH: if (timer == '0) begin
                       state_next = ELOW;
                       timer_next = EL_LOAD;
                   end else begin
                       timer_next = timer - 1'b1;
                   end
            ELOW:  if (timer == '0) begin
                       state_next = again ? SETUP : DONE;
                       timer_next = AS_LOAD;
                   end else begin
                       timer_next = timer - 1'b1;
                   end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pad-facing strobes are registered from the next state so they never glitch.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!lcd_reset) begin
            state       <= IDLE;
            timer       <= '0;
            poll_cnt    <= '0;
            sample_q    <= '0;
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            bus_req     <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_e       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_busy    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bus_req   <= owned_next || (state_next == ARB);
            lcd_rw    <= owned_next;
            lcd_rs    <= owned_next && rs_q;
            lcd_e     <= (state_next == EHIGH);
            rsp_valid <= (state_next == DONE);

            if (accept) begin
                rs_q     <= req_rs;
                poll_q   <= req_poll && !req_rs;
                poll_cnt <= '0;
            end
            if (capture) begin
                sample_q <= lcd_data_in;
                poll_cnt <= poll_cnt + 1'b1;
            end
            if (state_next == DONE) begin
                rsp_data    <= sample_q;
                rsp_busy    <= !rs_q && sample_q[7];
                rsp_timeout <= poll_q && sample_q[7] && (poll_cnt >= POLL_LIM);
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: expected responses are queued at request time
// and compared (data, flags, E-pulse count, latency) when rsp_valid appears.
module tb_lcd_bus_reader;

    logic       clk = 1'b0;
    logic       lcd_reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] lcd_data_in;
    logic       lcd_data_oe;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic       rsp_timeout;

    lcd_bus_reader #(.T_AS(3), .T_EH(25), .T_EL(25), .POLL_MAX(4)) dut (
        .clk(clk), .lcd_reset(lcd_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_poll(req_poll),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .lcd_data_in(lcd_data_in), .lcd_data_oe(lcd_data_oe),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_busy(rsp_busy), .rsp_timeout(rsp_timeout)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       busy;
        logic       timeout;
        int         pulses;
        int         latency;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // LCD model: reads 1..n_first of a request return first_val, later reads second_val.
    int         e_pulses  = 0;
    int         data_base = 0;
    int         n_first   = 1000;
    logic [7:0] first_val = 8'h00;
    logic [7:0] second_val = 8'h00;
    logic       e_prev    = 1'b0;
    logic       exp_rs    = 1'b0;
    int         rs_bad    = 0;
    int         rw_bad    = 0;
    int         oe_bad    = 0;

    assign lcd_data_in = ((e_pulses - data_base) <= n_first) ? first_val : second_val;

    always @(negedge clk) begin
        if (lcd_e && !e_prev) e_pulses++;
        e_prev = lcd_e;
        if (lcd_e) begin
            if (lcd_rs !== exp_rs) rs_bad++;
            if (lcd_rw !== 1'b1) rw_bad++;
        end
        if (lcd_data_oe !== 1'b0) oe_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_lcd(input logic [7:0] v1, input int nf, input logic [7:0] v2);
        data_base  = e_pulses;
        first_val  = v1;
        n_first    = nf;
        second_val = v2;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic b, input logic t,
                            input int p, input int lat);
        exp_t e;
        e.data = d; e.busy = b; e.timeout = t; e.pulses = p; e.latency = lat;
        sb.push_back(e);
    endtask

    // Handshake; returns at #1 into cycle 1 (the ARB cycle) after the accept edge.
    task automatic send(input logic rs, input logic poll);
        int w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        exp_rs    = rs;
        req_rs    = rs;
        req_poll  = poll;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready_after_accept", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic wait_rsp(input int start_cyc, input int budget);
        int   cyc = start_cyc;
        exp_t e;
        while (rsp_valid !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1; cyc++;
        end
        e = sb.pop_front();
        if (rsp_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
            return;
        end
        chk("latency", cyc, e.latency);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
        chk("rsp_busy", {31'd0, rsp_busy}, {31'd0, e.busy});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.timeout});
        chk("e_pulses", e_pulses - data_base, e.pulses);
        chk("bus_req_done", {31'd0, bus_req}, 32'd0);
        chk("lcd_rw_done", {31'd0, lcd_rw}, 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_data_hold", {24'd0, rsp_data}, {24'd0, e.data});
    endtask

    task automatic test_reset();
        int w = 0;
        lcd_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        chk("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_rsp", {21'd0, rsp_valid, rsp_data, rsp_busy, rsp_timeout}, 32'd0);
        lcd_reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Abort a read in the middle of its E-high phase.
        set_lcd(8'h4A, 1000, 8'h4A);
        send(1'b0, 1'b0);
        while (lcd_e !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("abort_e_reached", {31'd0, lcd_e}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        lcd_reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_lcd_e", {31'd0, lcd_e}, 32'd0);
        chk("abort_bus_req", {31'd0, bus_req}, 32'd0);
        chk("abort_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_no_rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
        end
        lcd_reset = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || lcd_e !== 1'b0) begin
                chk("abort_quiet_after_release", {30'd0, rsp_valid, lcd_e}, 32'd0);
                break;
            end
        end
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic test_status_read();
        set_lcd(8'h4A, 1000, 8'h4A);
        push_exp(8'h4A, 1'b0, 1'b0, 1, 55);
        send(1'b0, 1'b0);
        wait_rsp(1, 400);
        set_lcd(8'h9C, 1000, 8'h9C);
        push_exp(8'h9C, 1'b1, 1'b0, 1, 55);
        send(1'b0, 1'b0);
        wait_rsp(1, 400);
    endtask

    task automatic test_data_read();
        set_lcd(8'h33, 1000, 8'h33);
        push_exp(8'h33, 1'b0, 1'b0, 1, 55);
        send(1'b1, 1'b0);
        wait_rsp(1, 400);
        set_lcd(8'hB3, 1000, 8'hB3);
        push_exp(8'hB3, 1'b0, 1'b0, 1, 55);
        send(1'b1, 1'b1);
        wait_rsp(1, 400);
        chk("lcd_rs_during_e", rs_bad, 0);
    endtask

    task automatic test_poll();
        set_lcd(8'hC5, 3, 8'h45);
        push_exp(8'h45, 1'b0, 1'b0, 4, 4 * 53 + 2);
        send(1'b0, 1'b1);
        wait_rsp(1, 1000);
    endtask

    task automatic test_poll_timeout();
        set_lcd(8'h80, 1000, 8'h80);
        push_exp(8'h80, 1'b1, 1'b1, 4, 4 * 53 + 2);
        send(1'b0, 1'b1);
        wait_rsp(1, 1000);
    endtask

    task automatic test_arb_wait();
        int bad = 0;
        bus_gnt = 1'b0;
        set_lcd(8'h27, 1000, 8'h27);
        push_exp(8'h27, 1'b0, 1'b0, 1, 155);
        send(1'b1, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            if (lcd_rw !== 1'b0 || lcd_e !== 1'b0 || bus_req !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("arb_wait_bus_idle", bad, 0);
        bus_gnt = 1'b1;
        wait_rsp(101, 600);
    endtask

    initial begin
        lcd_reset = 1'b0;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_poll  = 1'b0;
        bus_gnt   = 1'b1;
        test_reset();
        test_status_read();
        test_data_read();
        test_poll();
        test_poll_timeout();
        test_arb_wait();
        chk("lcd_rw_high_during_e", rw_bad, 0);
        chk("data_oe_low", oe_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
